// File: rtl/i2s_rx_tdm.sv
// i2s_rx_tdm: I2S/TDM ADC capture engine, frame-sync master on the codec ADC port.
// It drives ADCLRC, shifts ADCDAT in MSB-first and offers each completed channel sample
// to a one-entry valid/ready holding register. It captures one frame, or frames back-to-back.
// Optional feature: define I2S_RX_OVERRUN_EN to drop new samples on a full, unaccepted
// holding register and raise the sticky overrun flag. When it is undefined, the latest
// sample overwrites the held one and overrun stays 0.
// Parameter legality: SLOT_WIDTH >= DATA_WIDTH + DATA_DELAY, NUM_CHANNELS even and >= 2.
module i2s_rx_tdm #(
   parameter int unsigned DATA_WIDTH   = 24,
   parameter int unsigned SLOT_WIDTH   = 32,
   parameter int unsigned NUM_CHANNELS = 2,
   parameter int unsigned DATA_DELAY   = 1,
   localparam int unsigned CHW = (NUM_CHANNELS > 2) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                  BCLK,
   input  logic                  reset,
   input  logic                  ADCDAT,
   input  logic                  start,
   input  logic                  continuous,
   input  logic                  stop,
   output logic                  ADCLRC,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CHW-1:0]        out_channel,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  frame_done,
   output logic                  busy,
   output logic                  overrun
);

   localparam int unsigned KW       = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
   localparam int unsigned LAST_BIT = DATA_DELAY + DATA_WIDTH - 1;
   localparam int unsigned HALF     = NUM_CHANNELS / 2;

   typedef enum logic [1:0] {StIdle, StRun, StStopping} state_e;

   state_e state_q, state_d;
   logic   cont_q, cont_d;
   logic   clear_ovr;

   // Frame counter fc is kept split as slot and in-slot bit: fc = slot * SLOT_WIDTH + k.
   logic [KW-1:0]  k_q, k_d;
   logic [CHW-1:0] slot_q, slot_d;
   logic           lrc_q, lrc_d;
   logic           slot_end, frame_end;

   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] done_data_q;
   logic [CHW-1:0]        done_ch_q;
   logic                  offer_q, offer_d;

   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CHW-1:0]        ch_q, ch_d;
   logic                  valid_q, valid_d;
   logic                  fdone_q, fdone_d;
   logic                  ovr_q, ovr_d;
   logic                  accept;

   assign busy      = (state_q != StIdle);
   assign slot_end  = (k_q == KW'(SLOT_WIDTH - 1));
   assign frame_end = slot_end && (slot_q == CHW'(NUM_CHANNELS - 1));

   // Next-state: mode latch, frame counter advance and end-of-frame decisions.
   always_comb begin
      state_d   = state_q;
      cont_d    = cont_q;
      k_d       = k_q;
      slot_d    = slot_q;
      clear_ovr = 1'b0;
      case (state_q)
         StIdle: begin
            k_d    = '0;
            slot_d = '0;
            if (start) begin
               state_d   = StRun;
               // A stop sampled with start limits the capture to a single frame.
               cont_d    = continuous & ~stop;
               clear_ovr = 1'b1;
            end
         end
         StRun, StStopping: begin
            if (frame_end) begin
               k_d    = '0;
               slot_d = '0;
               if (state_q == StStopping || !cont_q || stop) begin
                  state_d = StIdle;
               end
            end else begin
               if (slot_end) begin
                  k_d    = '0;
                  slot_d = slot_q + 1'b1;
               end else begin
                  k_d = k_q + 1'b1;
               end
               if (stop && state_q == StRun) begin
                  state_d = StStopping;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      // Frame sync follows the next counter value so it moves in the same cycle as fc.
      lrc_d = (slot_d >= CHW'(HALF));
   end

   // Serial capture: store ADCDAT into the bit addressed by k, flag the completed sample.
   always_comb begin
      shift_d = shift_q;
      offer_d = 1'b0;
      if (busy) begin
         for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            if (k_q == KW'(LAST_BIT - i)) begin
               shift_d[i] = ADCDAT;
            end
         end
         if (k_q == KW'(LAST_BIT)) begin
            offer_d = 1'b1;
         end
      end
   end

   // Holding register: load, drop or overwrite offered samples; handle downstream accept.
   always_comb begin
      data_d  = data_q;
      ch_d    = ch_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      fdone_d = 1'b0;
      accept  = valid_q & out_ready;
      if (clear_ovr) begin
         ovr_d = 1'b0;
      end
      if (offer_q) begin
         fdone_d = (done_ch_q == CHW'(NUM_CHANNELS - 1));
`ifdef I2S_RX_OVERRUN_EN
         if (!valid_q || accept) begin
            data_d  = done_data_q;
            ch_d    = done_ch_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
`else
         data_d  = done_data_q;
         ch_d    = done_ch_q;
         valid_d = 1'b1;
`endif
      end else if (accept) begin
         valid_d = 1'b0;
      end
   end

   // Control and counter state.
   always_ff @(posedge BCLK) begin
      if (reset) begin
         state_q <= StIdle;
         cont_q  <= 1'b0;
         k_q     <= '0;
         slot_q  <= '0;
         lrc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cont_q  <= cont_d;
         k_q     <= k_d;
         slot_q  <= slot_d;
         lrc_q   <= lrc_d;
      end
   end

   // Capture path: shift register plus a snapshot of the finished sample, so the next
   // slot may start shifting on the same edge that the snapshot is offered.
   always_ff @(posedge BCLK) begin
      if (reset) begin
         shift_q     <= '0;
         done_data_q <= '0;
         done_ch_q   <= '0;
         offer_q     <= 1'b0;
      end else begin
         shift_q <= shift_d;
         offer_q <= offer_d;
         if (offer_d) begin
            done_data_q <= shift_d;
            done_ch_q   <= slot_q;
         end
      end
   end

   // Output holding register and status flags.
   always_ff @(posedge BCLK) begin
      if (reset) begin
         data_q  <= '0;
         ch_q    <= '0;
         valid_q <= 1'b0;
         fdone_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         ch_q    <= ch_d;
         valid_q <= valid_d;
         fdone_q <= fdone_d;
         ovr_q   <= ovr_d;
      end
   end

   assign ADCLRC      = lrc_q;
   assign out_data    = data_q;
   assign out_channel = ch_q;
   assign out_valid   = valid_q;
   assign frame_done  = fdone_q;
   assign overrun     = ovr_q;

endmodule
